// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// State encoding and register-index width.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline
// stall and flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline:
// RAW interlocks, branch flush and memory-wait hold.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_forwarding,
  input  logic [REG_W-1:0] ID_src1,
  input  logic [REG_W-1:0] ID_src2,
  input  logic             ID_two_src,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] EXE_dst,
  input  logic             EXE_wb_en,
  input  logic             EXE_mem_read,
  input  logic [REG_W-1:0] MEM_dst,
  input  logic             MEM_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_IF,
  output logic             freeze_ID,
  output logic             bubble_EXE,
  output logic             flush_IF_ID,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [WCW-1:0] WLAST =
    WCW'(TIMEOUT_CYC - 1);

  state_e         r_state;
  state_e         w_next;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_timeout;
  logic           w_frz;

  logic w_m1e, w_m2e, w_m1m, w_m2m;
  logic w_exe_hit, w_mem_hit, w_raw;

  assign w_m1e = ID_valid && (EXE_dst == ID_src1);
  assign w_m2e = ID_valid && ID_two_src
              && (EXE_dst == ID_src2);
  assign w_m1m = ID_valid && (MEM_dst == ID_src1);
  assign w_m2m = ID_valid && ID_two_src
              && (MEM_dst == ID_src2);

  assign w_exe_hit = EXE_wb_en && (w_m1e || w_m2e);
  assign w_mem_hit = MEM_wb_en && (w_m1m || w_m2m);

  // With forwarding only a load result is too late
  assign w_raw = en_forwarding
               ? (w_exe_hit && EXE_mem_read)
               : (w_exe_hit || w_mem_hit);

  always_comb begin
    w_next = r_state;
    w_frz  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          w_next = MEM_WAIT;
          w_frz  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_next = RUN;
        end else begin
          w_frz = 1'b1;
          if (TO_EN && (r_wait_cnt == WLAST)) begin
            w_next = FAULT;
          end
        end
      end
      FAULT: begin
        w_frz = 1'b1;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != MEM_WAIT) begin
        r_wait_cnt <= '0;
      end else if (r_state == MEM_WAIT) begin
        r_wait_cnt <= r_wait_cnt + WCW'(1);
      end
      if (w_next == FAULT) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // A frozen EXE keeps any taken branch for after release
  always_comb begin
    freeze_IF   = 1'b0;
    freeze_ID   = 1'b0;
    bubble_EXE  = 1'b0;
    flush_IF_ID = 1'b0;
    freeze_pipe = 1'b0;
    if (rst_n) begin
      if (w_frz) begin
        freeze_pipe = 1'b1;
      end else if (branch_taken) begin
        flush_IF_ID = 1'b1;
        bubble_EXE  = 1'b1;
      end else if (w_raw) begin
        freeze_IF  = 1'b1;
        freeze_ID  = 1'b1;
        bubble_EXE = 1'b1;
      end
    end
  end

  assign mem_timeout = r_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze_IF || freeze_pipe),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_IF_ID),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: behavioural model with
// per-cycle compare, directed scenarios and random traffic.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_forwarding;
  logic [3:0]    ID_src1, ID_src2;
  logic          ID_two_src, ID_valid;
  logic [3:0]    EXE_dst;
  logic          EXE_wb_en, EXE_mem_read;
  logic [3:0]    MEM_dst;
  logic          MEM_wb_en;
  logic          branch_taken, mem_req, mem_ready;
  logic          freeze_IF, freeze_ID, bubble_EXE;
  logic          flush_IF_ID, freeze_pipe, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(
    .TIMEOUT_CYC (TO),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_forwarding (en_forwarding),
    .ID_src1       (ID_src1),
    .ID_src2       (ID_src2),
    .ID_two_src    (ID_two_src),
    .ID_valid      (ID_valid),
    .EXE_dst       (EXE_dst),
    .EXE_wb_en     (EXE_wb_en),
    .EXE_mem_read  (EXE_mem_read),
    .MEM_dst       (MEM_dst),
    .MEM_wb_en     (MEM_wb_en),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .freeze_IF     (freeze_IF),
    .freeze_ID     (freeze_ID),
    .bubble_EXE    (bubble_EXE),
    .flush_IF_ID   (flush_IF_ID),
    .freeze_pipe   (freeze_pipe),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_wait, m_fault;
  int m_waited, m_stall, m_flush;
  bit e_fif, e_fid, e_bub, e_fl, e_fp;

  function automatic bit reads(logic [3:0] d);
    bit r;
    r = 1'b0;
    if (ID_valid && d == ID_src1) r = 1'b1;
    if (ID_valid && ID_two_src && d == ID_src2) r = 1'b1;
    return r;
  endfunction

  function automatic bit hazard();
    bit exe_dep, mem_dep;
    exe_dep = EXE_wb_en && reads(EXE_dst);
    mem_dep = MEM_wb_en && reads(MEM_dst);
    if (en_forwarding) return exe_dep && EXE_mem_read;
    return exe_dep || mem_dep;
  endfunction

  always_comb begin
    e_fif = 1'b0;
    e_fid = 1'b0;
    e_bub = 1'b0;
    e_fl  = 1'b0;
    e_fp  = 1'b0;
    if (rst_n) begin
      e_fp = m_fault || (!mem_ready && (m_wait || mem_req));
      if (!e_fp) begin
        if (branch_taken) begin
          e_fl  = 1'b1;
          e_bub = 1'b1;
        end else if (hazard()) begin
          e_fif = 1'b1;
          e_fid = 1'b1;
          e_bub = 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait   <= 1'b0;
      m_fault  <= 1'b0;
      m_waited <= 0;
      m_stall  <= 0;
      m_flush  <= 0;
    end else begin
      if (!m_fault) begin
        if (m_wait) begin
          if (mem_ready) begin
            m_wait   <= 1'b0;
            m_waited <= 0;
          end else if (m_waited + 1 == TO) begin
            m_fault <= 1'b1;
          end else begin
            m_waited <= m_waited + 1;
          end
        end else if (mem_req && !mem_ready) begin
          m_wait   <= 1'b1;
          m_waited <= 0;
        end
      end
      if ((e_fif || e_fp) && m_stall < MAXC)
        m_stall <= m_stall + 1;
      if (e_fl && m_flush < MAXC)
        m_flush <= m_flush + 1;
    end
  end

  always @(negedge clk) begin
    chk("freeze_IF",   int'(freeze_IF),   int'(e_fif));
    chk("freeze_ID",   int'(freeze_ID),   int'(e_fid));
    chk("bubble_EXE",  int'(bubble_EXE),  int'(e_bub));
    chk("flush_IF_ID", int'(flush_IF_ID), int'(e_fl));
    chk("freeze_pipe", int'(freeze_pipe), int'(e_fp));
    chk("mem_timeout", int'(mem_timeout), int'(m_fault));
    chk("stall_cnt",   int'(stall_cnt),   m_stall);
    chk("flush_cnt",   int'(flush_cnt),   m_flush);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    ID_src1 = 4'd0; ID_src2 = 4'd0;
    ID_two_src = 1'b0; ID_valid = 1'b0;
    EXE_dst = 4'd0; EXE_wb_en = 1'b0; EXE_mem_read = 1'b0;
    MEM_dst = 4'd0; MEM_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // apply current inputs for one cycle; returns at negedge
  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(bit fwd);
    rst_n = 1'b0;
    idle();
    en_forwarding = fwd;
    at_neg();
    next_cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_forwarding = 1'b1;
    idle();
    #1;

    // reset hides a pending memory hazard
    mem_req = 1'b1;
    at_neg();
    chk("rst_freeze_pipe", int'(freeze_pipe), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    next_cyc();

    // load-use with forwarding: one bubble
    do_reset(1'b1);
    EXE_dst = 4'd3; EXE_wb_en = 1'b1; EXE_mem_read = 1'b1;
    ID_valid = 1'b1; ID_src1 = 4'd3;
    at_neg();
    chk("lu_freeze_IF", int'(freeze_IF), 1);
    chk("lu_bubble", int'(bubble_EXE), 1);
    next_cyc();
    EXE_wb_en = 1'b0; EXE_mem_read = 1'b0;
    MEM_dst = 4'd3; MEM_wb_en = 1'b1;
    at_neg();
    chk("lu_release", int'(freeze_IF), 0);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    next_cyc();

    // no forwarding: EXE match on src2 stalls 2 cycles
    do_reset(1'b0);
    EXE_dst = 4'd2; EXE_wb_en = 1'b1;
    ID_valid = 1'b1; ID_two_src = 1'b1;
    ID_src1 = 4'd5; ID_src2 = 4'd2;
    at_neg();
    chk("nf_stall1", int'(freeze_ID), 1);
    next_cyc();
    EXE_wb_en = 1'b0;
    MEM_dst = 4'd2; MEM_wb_en = 1'b1;
    at_neg();
    chk("nf_stall2", int'(freeze_IF), 1);
    next_cyc();
    MEM_wb_en = 1'b0;
    at_neg();
    chk("nf_done", int'(freeze_IF), 0);
    chk("nf_stall_cnt", int'(stall_cnt), 2);
    next_cyc();
    EXE_dst = 4'd2; EXE_wb_en = 1'b1; ID_two_src = 1'b0;
    at_neg();
    chk("nf_one_src", int'(freeze_IF), 0);
    next_cyc();

    // memory wait with a branch held behind it
    do_reset(1'b1);
    mem_req = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("mw_freeze", int'(freeze_pipe), 1);
      chk("mw_no_flush", int'(flush_IF_ID), 0);
      next_cyc();
    end
    mem_ready = 1'b1;
    at_neg();
    chk("mw_release", int'(freeze_pipe), 0);
    chk("mw_flush", int'(flush_IF_ID), 1);
    next_cyc();
    idle();
    at_neg();
    chk("mw_stall_cnt", int'(stall_cnt), 4);
    chk("mw_flush_cnt", int'(flush_cnt), 1);
    next_cyc();

    // branch beats load-use
    do_reset(1'b1);
    EXE_dst = 4'd7; EXE_wb_en = 1'b1; EXE_mem_read = 1'b1;
    ID_valid = 1'b1; ID_src1 = 4'd7; branch_taken = 1'b1;
    at_neg();
    chk("bl_flush", int'(flush_IF_ID), 1);
    chk("bl_bubble", int'(bubble_EXE), 1);
    chk("bl_freeze_IF", int'(freeze_IF), 0);
    next_cyc();

    // timeout: 1 RUN cycle + 8 wait cycles, then FAULT
    do_reset(1'b1);
    mem_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      at_neg();
      chk("to_pending", int'(mem_timeout), 0);
      next_cyc();
    end
    mem_req = 1'b0; mem_ready = 1'b1;
    at_neg();
    chk("to_flag", int'(mem_timeout), 1);
    chk("to_freeze", int'(freeze_pipe), 1);
    next_cyc();
    #1;
    rst_n = 1'b0;
    #1;
    chk("to_async_flag", int'(mem_timeout), 0);
    chk("to_async_freeze", int'(freeze_pipe), 0);
    chk("to_async_cnt", int'(stall_cnt), 0);
    next_cyc();

    // random traffic in both modes
    for (int ph = 0; ph < 2; ph++) begin
      do_reset(ph[0]);
      for (int c = 0; c < 1500; c++) begin
        bit big;
        big = ($urandom_range(0, 4) == 0);
        ID_src1 = 4'($urandom_range(0, big ? 15 : 3));
        ID_src2 = 4'($urandom_range(0, big ? 15 : 3));
        EXE_dst = 4'($urandom_range(0, big ? 15 : 3));
        MEM_dst = 4'($urandom_range(0, big ? 15 : 3));
        ID_valid     = ($urandom_range(0, 3) != 0);
        ID_two_src   = $urandom_range(0, 1) != 0;
        EXE_wb_en    = ($urandom_range(0, 9) < 7);
        EXE_mem_read = $urandom_range(0, 1) != 0;
        MEM_wb_en    = ($urandom_range(0, 9) < 7);
        branch_taken = ($urandom_range(0, 99) < 15);
        mem_req      = ($urandom_range(0, 9) < 3);
        mem_ready    = ($urandom_range(0, 99) <
                        (ph == 0 ? 50 : 25));
        rst_n        = ($urandom_range(0, 149) != 0);
        at_neg();
        next_cyc();
      end
      rst_n = 1'b1;
    end

    idle();
    at_neg();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Consumes register-dependency info from ID/EXE/MEM, the EXE branch decision and the MEM-stage memory handshake.
- Drives per-stage freeze/flush/bubble controls so that it complements the EXE-stage operand forwarding unit:
  - forwarding on: only load-use hazards stall.
  - forwarding off: every RAW hazard stalls.
- Also holds the whole pipeline during multi-cycle memory accesses, with timeout detection and performance counters.

Parameters:
- TIMEOUT_CYC, 255, max cycles in MEM_WAIT before fault; 0 disables timeout.
- CNT_W, 16, width of the saturating stall_cnt/flush_cnt counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en_forwarding  in  1  forwarding mode enable (static during operation).
- ID_src1  in  4  first source register of instruction in ID.
- ID_src2  in  4  second source register of instruction in ID.
- ID_two_src  in  1  ID instruction reads ID_src2.
- ID_valid  in  1  ID holds a real instruction that reads ID_src1.
- EXE_dst  in  4  destination register of EXE instruction.
- EXE_wb_en  in  1  EXE instruction writes back.
- EXE_mem_read  in  1  EXE instruction is a load.
- MEM_dst  in  4  destination register of MEM instruction.
- MEM_wb_en  in  1  MEM instruction writes back.
- branch_taken  in  1  EXE resolved a taken branch.
- mem_req  in  1  MEM stage issuing a data-memory access this cycle.
- mem_ready  in  1  memory completes the access this cycle.
- freeze_IF  out  1  hold PC and IF/ID register.
- freeze_ID  out  1  hold ID-stage decode.
- bubble_EXE  out  1  load NOP into ID/EXE register.
- flush_IF_ID  out  1  clear IF/ID register (branch).
- freeze_pipe  out  1  hold all pipeline registers.
- mem_timeout  out  1  sticky fault flag.
- stall_cnt  out  CNT_W  cycles with freeze_IF or freeze_pipe asserted.
- flush_cnt  out  CNT_W  number of branch flushes applied.

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - All combinational outputs evaluate to 0 while reset is held.
- Match terms:
  - m1(X) = ID_valid && X_dst==ID_src1.
  - m2(X) = ID_valid && ID_two_src && X_dst==ID_src2.
- raw_hazard:
  - en_forwarding=1: EXE_wb_en && EXE_mem_read && (m1(EXE) || m2(EXE)).
  - en_forwarding=0: (EXE_wb_en && (m1(EXE)||m2(EXE))) || (MEM_wb_en && (m1(MEM)||m2(MEM))).
- States:
  - RUN: normal flow.
  - MEM_WAIT: memory access outstanding.
  - FAULT: timeout; terminal until reset.
- freeze_pipe (combinational) = (state==RUN && mem_req && !mem_ready) || (state==MEM_WAIT && !mem_ready) || state==FAULT.
- Transitions:
  - RUN -> MEM_WAIT when mem_req && !mem_ready.
  - MEM_WAIT -> RUN on mem_ready; freeze_pipe=0 in that same cycle.
  - MEM_WAIT -> FAULT when TIMEOUT_CYC!=0 and wait_cnt==TIMEOUT_CYC-1 with !mem_ready.
  - wait_cnt increments each MEM_WAIT cycle and clears on entry to RUN.
  - FAULT: mem_timeout=1 (registered, sticky), freeze_pipe=1 until reset.
- Priority, highest first:
  1. freeze_pipe=1: freeze_IF, freeze_ID, bubble_EXE and flush_IF_ID all 0. A branch_taken is not lost: the frozen EXE register re-presents it after release.
  2. branch_taken: flush_IF_ID=1, bubble_EXE=1; raw_hazard ignored because the ID instruction is squashed.
  3. raw_hazard: freeze_IF=1, freeze_ID=1, bubble_EXE=1 in the same cycle.
- Load-use with forwarding costs exactly 1 bubble. In the next cycle the load is in MEM and raw_hazard is 0.
- Without forwarding, the stall persists until no EXE/MEM match remains: 2 cycles for an EXE match, 1 cycle for a MEM-only match.
- Counters:
  - stall_cnt increments on cycles with (freeze_IF || freeze_pipe).
  - flush_cnt increments on cycles with flush_IF_ID.
  - Both saturate at all-ones and do not wrap.
- Register R15 receives no special treatment; matching is purely on the 4-bit compare.

Decomposition:
- Shared package holds:
  - state enum: RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2.
  - register-index width constant REG_W=4.
- One natural sub-module: sat_counter (parameterised width, inc input, async active-low reset), instantiated twice.
- Hazard-compare logic stays inline.

Test Plan:
- Load-use, forwarding on: EXE load r3 (EXE_mem_read=1, wb_en=1, dst=3), ID_src1=3 -> freeze_IF=freeze_ID=bubble_EXE=1 for exactly 1 cycle; stall_cnt=1.
- Forwarding off, ADD r2 in EXE then ID reads r2 as src2 with ID_two_src=1 -> 2 stall cycles; with ID_two_src=0 -> no stall.
- Memory wait: mem_req=1, mem_ready low 4 cycles -> freeze_pipe=1 for 4 cycles, 0 on the mem_ready cycle, state back to RUN; stall_cnt=4.
- Branch during wait: branch_taken=1 while freeze_pipe=1 -> flush_IF_ID=0 until release, then flush_IF_ID=1 for 1 cycle; flush_cnt=1.
- Timeout with TIMEOUT_CYC=8 and mem_ready held 0 -> mem_timeout=1 after 8 wait cycles; freeze_pipe stays 1; rst_n pulse clears everything asynchronously.
- Branch and load-use in the same cycle -> flush_IF_ID=1, bubble_EXE=1, freeze_IF=0.
